// File: rtl/mmm_par_engine_if.sv
// Memory-read and result-stream bundle of mmm_par_engine; the engine side is master,
// the memory block plus stream consumer is slave.
interface mmm_par_engine_if #(
  parameter int INW  = 12,
  parameter int OUTW = 32,
  parameter int P    = 4,
  parameter int AAW  = 6,
  parameter int BAW  = 4
);
  logic [AAW-1:0]   A_read_addr;
  logic [INW-1:0]   A_data;
  logic [BAW-1:0]   B_read_addr;
  logic [P*INW-1:0] B_data;
  logic [OUTW-1:0]  OUTPUT_TDATA;
  logic             OUTPUT_TVALID;
  logic             OUTPUT_TLAST;
  logic             OUTPUT_TREADY;

  modport master (
    output A_read_addr, B_read_addr, OUTPUT_TDATA, OUTPUT_TVALID, OUTPUT_TLAST,
    input  A_data, B_data, OUTPUT_TREADY
  );
  modport slave (
    input  A_read_addr, B_read_addr, OUTPUT_TDATA, OUTPUT_TVALID, OUTPUT_TLAST,
    output A_data, B_data, OUTPUT_TREADY
  );
endinterface

// File: rtl/mmm_par_engine.sv
// C = A*B with P MAC lanes per (row, column-block) group; result 3 cycles after last issue.
// Groups start only with P free FIFO credits, so TREADY backpressure stalls issue, never a product.
module mmm_par_engine #(
  parameter int INW    = 12,
  parameter int OUTW   = 32,
  parameter int MAXM   = 8,
  parameter int MAXN   = 8,
  parameter int MAXK   = 8,
  parameter int P      = 4,
  parameter int FIFO_D = 16,
  localparam int NB  = (MAXN + P - 1) / P,
  localparam int KB  = $clog2(MAXK + 1),
  localparam int MB  = $clog2(MAXM + 1),
  localparam int NWB = $clog2(MAXN + 1),
  localparam int AAW = $clog2(MAXM * MAXK),
  localparam int BAW = $clog2(MAXK * NB)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           matrices_loaded,
  input  logic [KB-1:0]  K,
  input  logic [MB-1:0]  M_CFG,
  input  logic [NWB-1:0] N_CFG,
  output logic           compute_finished,
  mmm_par_engine_if.master bus
);
  localparam int FAW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW  = $clog2(FIFO_D + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_WAIT_LOW} state_t;

  state_t           state_q, state_d;
  logic [MB-1:0]    m_q, m_d, row_q, row_d;
  logic [NWB-1:0]   n_q, n_d, nbr_q, nbr_d, cb_q, cb_d;
  logic [KB-1:0]    k_q, k_d, idx_q, idx_d;
  logic [CW-1:0]    credits_q, credits_d, count_q, count_d;
  logic             s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic             s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic [NWB-1:0]   s1_cb_q, s1_cb_d, s2_cb_q, s2_cb_d, wb_cb_q, wb_cb_d;
  logic             wb_q, wb_d;
  logic [OUTW-1:0]  prod_q [P], prod_d [P], acc_q [P], acc_d [P];
  logic [OUTW-1:0]  fifo_dat_q [FIFO_D], fifo_dat_d [FIFO_D];
  logic             fifo_last_q [FIFO_D], fifo_last_d [FIFO_D];
  logic [FAW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             issue, start, last_idx, last_cb, last_row, pop;
  logic signed [2*INW-1:0] pf;
  int               nv, col0;

  function automatic logic [FAW-1:0] ptr_add(input logic [FAW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= FIFO_D) s = s - FIFO_D;
    return FAW'(s);
  endfunction

  always_comb begin
    issue    = (state_q == S_RUN) && ((idx_q != '0) || (int'(credits_q) >= P));
    start    = issue && (idx_q == '0);
    last_idx = (int'(idx_q) == int'(k_q) - 1);
    last_cb  = (int'(cb_q) == int'(nbr_q) - 1);
    last_row = (int'(row_q) == int'(m_q) - 1);
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    nbr_d    = nbr_q;
    row_d    = row_q;
    cb_d     = cb_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: if (matrices_loaded) begin
        state_d = S_RUN;
        m_d     = M_CFG;
        n_d     = N_CFG;
        k_d     = K;
        nbr_d   = NWB'((int'(N_CFG) + P - 1) / P);
      end
      S_RUN: if (issue) begin
        if (!last_idx) begin
          idx_d = KB'(int'(idx_q) + 1);
        end else begin
          idx_d = '0;
          if (!last_cb) begin
            cb_d = NWB'(int'(cb_q) + 1);
          end else begin
            cb_d = '0;
            if (!last_row) begin
              row_d = MB'(int'(row_q) + 1);
            end else begin
              row_d   = '0;
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN:    if (!(s1_vld_q || s2_vld_q || wb_q)) state_d = S_DONE;
      S_DONE:     state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!matrices_loaded) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Memory data arrives the cycle after issue; product registers one cycle later.
  always_comb begin
    s1_vld_d   = issue;
    s1_first_d = start;
    s1_last_d  = issue && last_idx;
    s1_cb_d    = cb_q;
    s2_vld_d   = s1_vld_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    s2_cb_d    = s1_cb_q;
    wb_d       = s2_vld_q && s2_last_q;
    wb_cb_d    = s2_cb_q;
    pf         = '0;
    for (int j = 0; j < P; j++) begin
      pf        = $signed(bus.A_data) * $signed(bus.B_data[j*INW +: INW]);
      prod_d[j] = OUTW'(pf);
      if (s2_vld_q) acc_d[j] = s2_first_q ? prod_q[j] : acc_q[j] + prod_q[j];
      else          acc_d[j] = acc_q[j];
    end
  end

  // Lanes past N_CFG are dropped here and their reserved credits handed back.
  always_comb begin
    pop  = (count_q != '0) && bus.OUTPUT_TREADY;
    col0 = int'(wb_cb_q) * P;
    nv   = 0;
    if (wb_q) nv = ((int'(n_q) - col0) >= P) ? P : (int'(n_q) - col0);
    fifo_dat_d  = fifo_dat_q;
    fifo_last_d = fifo_last_q;
    for (int j = 0; j < P; j++) begin
      if (j < nv) begin
        fifo_dat_d[ptr_add(wptr_q, j)]  = acc_q[j];
        fifo_last_d[ptr_add(wptr_q, j)] = ((col0 + j) == (int'(n_q) - 1));
      end
    end
    wptr_d    = ptr_add(wptr_q, nv);
    rptr_d    = ptr_add(rptr_q, pop ? 1 : 0);
    count_d   = CW'(int'(count_q) + nv - (pop ? 1 : 0));
    credits_d = CW'(int'(credits_q) + (pop ? 1 : 0) + (wb_q ? P - nv : 0) - (start ? P : 0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      nbr_q       <= '0;
      row_q       <= '0;
      cb_q        <= '0;
      idx_q       <= '0;
      credits_q   <= CW'(FIFO_D);
      count_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_cb_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_cb_q     <= '0;
      wb_q        <= 1'b0;
      wb_cb_q     <= '0;
      prod_q      <= '{default: '0};
      acc_q       <= '{default: '0};
      fifo_dat_q  <= '{default: '0};
      fifo_last_q <= '{default: 1'b0};
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      nbr_q       <= nbr_d;
      row_q       <= row_d;
      cb_q        <= cb_d;
      idx_q       <= idx_d;
      credits_q   <= credits_d;
      count_q     <= count_d;
      s1_vld_q    <= s1_vld_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_cb_q     <= s1_cb_d;
      s2_vld_q    <= s2_vld_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_cb_q     <= s2_cb_d;
      wb_q        <= wb_d;
      wb_cb_q     <= wb_cb_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      fifo_dat_q  <= fifo_dat_d;
      fifo_last_q <= fifo_last_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  assign bus.A_read_addr   = AAW'(int'(row_q) * int'(k_q) + int'(idx_q));
  assign bus.B_read_addr   = BAW'(int'(idx_q) * int'(nbr_q) + int'(cb_q));
  assign bus.OUTPUT_TVALID = (count_q != '0);
  assign bus.OUTPUT_TDATA  = fifo_dat_q[rptr_q];
  assign bus.OUTPUT_TLAST  = fifo_last_q[rptr_q];
  assign compute_finished  = (state_q == S_DONE);
endmodule
